// File: rtl/mux_pkg.sv
// Shared definitions for the registered N-to-1 multiplexer (mux_nx1_reg).
// Holds the mode encodings and the round-robin pointer reset helper.
// Optional parity output is enabled by defining MUX_NX1_REG_PARITY_EN.
package mux_pkg;

  // Mode encodings for the mode input.
  localparam logic MUX_MODE_SEL = 1'b0;  // explicit select via sel
  localparam logic MUX_MODE_RR  = 1'b1;  // round-robin arbitration

  // Reset value of the round-robin pointer: N-1, so that the search
  // after reset starts at channel 0 and channel 0 has first priority.
  function automatic int rr_ptr_rst(input int n);
    return n - 1;
  endfunction

endpackage

// File: rtl/mux_nx1_reg_rr_arbiter.sv
// Round-robin arbiter used by mux_nx1_reg.
// Searches requests starting one past ptr, wrapping modulo N, and returns
// the first requester as a one-hot grant plus its encoded index.
// Purely combinational; the caller owns the pointer register.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [SW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [SW-1:0] gnt_idx_o,
  output logic          gnt_valid_o
);

  // Walk channels ptr+1, ptr+2, ... (mod N); first requester wins.
  always_comb begin
    int cand;
    cand        = 0;
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(ptr_i) + k) % N;
      if (!gnt_valid_o && req_i[cand]) begin
        gnt_valid_o = 1'b1;
        gnt_o[cand] = 1'b1;
        gnt_idx_o   = SW'(cand);
      end
    end
  end

endmodule

// File: rtl/mux_nx1_reg.sv
// Parametrised N-channel, W-bit registered multiplexer.
// mode=0 grants the channel named by sel; mode=1 grants round-robin.
// A single output register holds the accepted word; a channel is accepted
// only when that slot is empty or being drained in the same cycle.
// Optional feature: define MUX_NX1_REG_PARITY_EN to add out_par, the
// XOR-reduction of the accepted word, registered alongside out_data.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is combinational from the current grant and the slot
// state; a source must hold in_valid/in_data until it sees in_ready. The
// output side holds out_valid/out_data/out_ch until out_ready is seen.
module mux_nx1_reg
  import mux_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mode,
  input  logic [$clog2(N)-1:0]   sel,
  input  logic [N-1:0]           in_valid,
  input  logic [N*W-1:0]         in_data,
  output logic [N-1:0]           in_ready,
  output logic                   out_valid,
  output logic [W-1:0]           out_data,
  output logic [$clog2(N)-1:0]   out_ch,
  input  logic                   out_ready
`ifdef MUX_NX1_REG_PARITY_EN
  ,
  output logic                   out_par
`endif
);

  // Channel-index width, derived from N and not overridable.
  localparam int SW = $clog2(N);
  localparam logic [SW-1:0] RR_PTR_RST = SW'(rr_ptr_rst(N));

  // Output register and round-robin pointer.
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q,  out_data_d;
  logic [SW-1:0] out_ch_q,    out_ch_d;
  logic [SW-1:0] rr_ptr_q,    rr_ptr_d;
`ifdef MUX_NX1_REG_PARITY_EN
  logic          out_par_q,   out_par_d;
`endif

  // Grant path signals.
  logic          slot_free;
  logic          sel_hit;
  logic [N-1:0]  sel_onehot;
  logic [N-1:0]  rr_gnt;
  logic [SW-1:0] rr_idx;
  logic          rr_valid;
  logic          grant_valid;
  logic [SW-1:0] grant_idx;
  logic [N-1:0]  grant_onehot;
  logic [W-1:0]  grant_data;
  logic          accept;

  rr_arbiter #(
    .N  (N),
    .SW (SW)
  ) u_rr_arbiter (
    .req_i       (in_valid),
    .ptr_i       (rr_ptr_q),
    .gnt_o       (rr_gnt),
    .gnt_idx_o   (rr_idx),
    .gnt_valid_o (rr_valid)
  );

  // The slot can take a new word if it is empty or emptying this cycle.
  assign slot_free = !out_valid_q || out_ready;

  // Explicit-select decode; a sel value >= N matches no channel and
  // therefore simply grants nothing.
  always_comb begin
    sel_hit    = 1'b0;
    sel_onehot = '0;
    for (int i = 0; i < N; i++) begin
      if (sel == SW'(i)) begin
        sel_hit       = in_valid[i];
        sel_onehot[i] = in_valid[i];
      end
    end
  end

  // Choose the grant source according to mode (takes effect this cycle).
  always_comb begin
    grant_valid  = 1'b0;
    grant_idx    = '0;
    grant_onehot = '0;
    if (mode == MUX_MODE_RR) begin
      grant_valid  = rr_valid;
      grant_idx    = rr_idx;
      grant_onehot = rr_gnt;
    end else begin
      grant_valid  = sel_hit;
      grant_idx    = sel;
      grant_onehot = sel_onehot;
    end
  end

  // Pick the granted channel's data word out of the packed input bus.
  always_comb begin
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == SW'(i)) begin
        grant_data = in_data[i*W +: W];
      end
    end
  end

  // Accept only with a grant, a free slot and reset released.
  assign accept   = rst_n && grant_valid && slot_free;
  assign in_ready = accept ? grant_onehot : '0;

  // Next-state for the output register and round-robin pointer.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    rr_ptr_d    = rr_ptr_q;
`ifdef MUX_NX1_REG_PARITY_EN
    out_par_d   = out_par_q;
`endif
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = grant_data;
      out_ch_d    = grant_idx;
`ifdef MUX_NX1_REG_PARITY_EN
      out_par_d   = ^grant_data;
`endif
      // The pointer only advances on a round-robin transfer.
      if (mode == MUX_MODE_RR) begin
        rr_ptr_d = grant_idx;
      end
    end else if (out_valid_q && out_ready) begin
      // Drain with nothing new: data and channel keep their last values.
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_ptr_q    <= RR_PTR_RST;
`ifdef MUX_NX1_REG_PARITY_EN
      out_par_q   <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      rr_ptr_q    <= rr_ptr_d;
`ifdef MUX_NX1_REG_PARITY_EN
      out_par_q   <= out_par_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
`ifdef MUX_NX1_REG_PARITY_EN
  assign out_par   = out_par_q;
`endif

endmodule

// File: doc/mux_nx1_reg.md
Name: mux_nx1_reg

Overview:
- Parametrised N-channel, W-bit registered multiplexer with valid/ready handshakes on every input and on the output.
- Two modes: explicit-select (4x1 mux behaviour, generalised) and round-robin arbitration.
- One-entry output register, so a channel is accepted only when the output slot is free or draining.
- Used in the MIPS datapath to merge operand, writeback or memory-request sources into one registered stream.

Parameters:
- N, 4, number of input channels (2..16).
- W, 32, data width in bits.
- SW, $clog2(N), select / channel-index width (derived, not overridable).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- mode  input  1  0 = explicit select, 1 = round-robin.
- sel  input  SW  channel index used when mode=0.
- in_valid  input  N  per-channel valid; bit i belongs to channel i.
- in_data  input  N*W  channel i occupies bits [i*W +: W].
- in_ready  output  N  per-channel accept; at most one bit high per cycle.
- out_valid  output  1  output register holds data.
- out_data  output  W  registered data.
- out_ch  output  SW  index of the channel that supplied out_data.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset is synchronous: on a clk edge with rst_n=0, out_valid=0, out_data=0, out_ch=0 and rr_ptr=N-1, so channel 0 has first priority. in_ready is combinational and is all-zero while rst_n=0.
- Slot free: slot_free = !out_valid || out_ready.
- Mode 0 grant:
  - grant = sel when sel < N and in_valid[sel]=1; otherwise no grant.
  - If sel >= N, nothing is granted and no error is raised.
- Mode 1 grant:
  - Search channels rr_ptr+1, rr_ptr+2, ... modulo N, wrapping from N-1 to 0.
  - The first channel with in_valid=1 wins.
  - rr_ptr updates to the winner only on an accepted transfer.
- Ready: in_ready[g] = slot_free for the granted channel g; all other bits are 0.
- Transfer: accept = grant exists && slot_free. On accept, at the next edge:
  - out_data is loaded with in_data[g] and out_ch with g.
  - out_valid is set to 1.
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 transfer per cycle while out_ready=1.
- Drain: out_valid && out_ready && !accept clears out_valid at the next edge. out_data and out_ch keep their last values.
- Simultaneous drain and accept: out_valid stays 1 and the new data is loaded (no bubble).
- Stall: while out_valid=1 && out_ready=0, out_data and out_ch are held stable and all in_ready bits are 0.
- Mode or sel change: takes effect in the same cycle (combinational grant). rr_ptr is not reset by a mode change.
- Reset mid-operation: a pending output is discarded (out_valid=0 at the next edge) and rr_ptr returns to N-1.
- Sources must hold in_valid and in_data until accepted. Dropping valid before accept is legal, but the data is lost.

Optional Feature:
- Macro: MUX_NX1_REG_PARITY_EN.
- When defined:
  - Adds output port out_par (1 bit), registered together with out_data, equal to ^in_data[g] of the accepted word.
  - Reset value of out_par is 0.
  - out_par is held during a stall, like out_data.
- When undefined: the port and its logic are absent, and all other behaviour is identical.

Decomposition:
- Shared package mux_pkg contains:
  - Mode encodings MUX_MODE_SEL=1'b0 and MUX_MODE_RR=1'b1.
  - The reset value of rr_ptr, defined as N-1.
- Sub-module rr_arbiter (N-wide request/grant, rr_ptr input, one-hot grant plus encoded index output) is instantiated once.
- The select path, ready logic and output register stay in mux_nx1_reg.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with all in_valid=1 -> in_ready=0000, out_valid=0, out_data=0, out_ch=0. Release -> in mode 1 channel 0 is accepted first.
- Mode 0 sweep: N=4, W=32, in_data channel i = 32'hA0+i, out_ready=1.
  - Step sel 0..3 with all in_valid=1 -> out_data = A0..A3 and out_ch = sel, each one cycle later.
  - Drive sel=3 with in_valid=0111 -> no accept and out_valid=0.
- Round robin: mode=1, all in_valid=1, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3 with no bubbles.
  - Then in_valid=1010 -> sequence 1,3,1,3.
- Backpressure: out_ready=0 for 3 cycles after one accept -> out_data and out_ch are stable and in_ready=0000. Raise out_ready -> the next channel is accepted on that same cycle and out_valid stays 1.
- Reset mid-stall: out_valid=1, out_ready=0, assert rst_n=0 for one edge -> out_valid=0 and rr_ptr is restored, so channel 0 is granted next in mode 1.
- Parity (macro defined): accept 32'h0000_0007 -> out_par=1; accept 32'h0000_0003 -> out_par=0.
